// File: rtl/load_data_unit_if.sv
// Request/response and read-bus signals of the load data unit, grouped as a single bundle.
// The master modport is the load data unit. The slave modport is the core plus memory side.
interface load_data_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_addr;
    logic [2:0]      req_func3;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;

    logic            arvalid;
    logic            arready;
    logic [31:0]     araddr;
    logic [2:0]      arsize;

    logic            rvalid;
    logic            rready;
    logic [XLEN-1:0] rdata;
    logic [1:0]      rresp;

    modport master (
        input  req_valid, req_addr, req_func3, rsp_ready, arready, rvalid, rdata, rresp,
        output req_ready, rsp_valid, rsp_data, rsp_err, arvalid, araddr, arsize, rready
    );

    modport slave (
        output req_valid, req_addr, req_func3, rsp_ready, arready, rvalid, rdata, rresp,
        input  req_ready, rsp_valid, rsp_data, rsp_err, arvalid, araddr, arsize, rready
    );
endinterface

// File: rtl/load_data_unit.sv
// RISC-V load unit: aligns and extends loads, taking 3 cycles minimum and 5 when a load crosses a bus word.
// Every handshake is held until accepted. Macro LDU_MISALIGN_EN enables two-beat crossing loads; without it they return an error.
module load_data_unit #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NS0_BASE = 32'h2000_0000,
    parameter logic [31:0] NS0_MASK = 32'hFFFF_F000,
    parameter logic [31:0] NS1_BASE = 32'h1000_0000,
    parameter logic [31:0] NS1_MASK = 32'hFFFF_FFF8,
    parameter logic [31:0] NS2_BASE = 32'h3000_0000,
    parameter logic [31:0] NS2_MASK = 32'hF000_0000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    load_data_unit_if.master bus
);
    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);

`ifdef LDU_MISALIGN_EN
    typedef enum logic [2:0] {IDLE, AR1, R1, AR2, R2, RSP} state_t;
`else
    typedef enum logic [2:0] {IDLE, AR1, R1, RSP} state_t;
`endif

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [2:0]      func3_q, func3_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            err_q, err_d;
    logic            ns_q;
    logic            reject;
    logic [OFFW-1:0] sh;
    logic [31:0]     aligned;
`ifdef LDU_MISALIGN_EN
    logic [XLEN-1:0]   beat1_q, beat1_d;
    logic [2*XLEN-1:0] merged;
    logic              cross_q;
`endif

    function automatic logic no_shift(input logic [31:0] a);
        return ((a & NS0_MASK) == NS0_BASE) ||
               ((a & NS1_MASK) == NS1_BASE) ||
               ((a & NS2_MASK) == NS2_BASE);
    endfunction

    function automatic logic crosses(input logic [31:0] a, input logic [2:0] f3);
        logic [3:0] end_b;
        end_b = 4'(a[OFFW-1:0]) + (4'd1 << f3[1:0]);
        return !no_shift(a) && (end_b > 4'(BYTES));
    endfunction

    function automatic logic illegal(input logic [2:0] f3);
        return (XLEN == 32) && ((f3[1:0] == 2'b11) || (f3 == 3'b110));
    endfunction

    // Push the loaded bytes to the top of the word, then shift back arithmetically or logically.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw, input logic [2:0] f3);
        logic [XLEN-1:0] up;
        int              nbits;
        int              k;
        nbits = 8 << f3[1:0];
        k     = (nbits >= XLEN) ? 0 : XLEN - nbits;
        up    = raw << k;
        return f3[2] ? (up >> k) : $unsigned($signed(up) >>> k);
    endfunction

    assign ns_q    = no_shift(addr_q);
    assign sh      = ns_q ? '0 : addr_q[OFFW-1:0];
    assign aligned = {addr_q[31:OFFW], {OFFW{1'b0}}};
`ifdef LDU_MISALIGN_EN
    assign cross_q = crosses(addr_q, func3_q);
    assign reject  = illegal(bus.req_func3);
`else
    assign reject  = illegal(bus.req_func3) || crosses(bus.req_addr, bus.req_func3);
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        func3_d = func3_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef LDU_MISALIGN_EN
        beat1_d = beat1_q;
        merged  = {bus.rdata, beat1_q} >> {sh, 3'b000};
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    func3_d = bus.req_func3;
                    if (reject) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = RSP;
                    end else begin
                        state_d = AR1;
                    end
                end
            end
            AR1: if (bus.arready) state_d = R1;
            R1: begin
                if (bus.rvalid) begin
                    if (bus.rresp != 2'b00) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = RSP;
`ifdef LDU_MISALIGN_EN
                    end else if (cross_q) begin
                        beat1_d = bus.rdata;
                        state_d = AR2;
`endif
                    end else begin
                        err_d   = 1'b0;
                        data_d  = extend(bus.rdata >> {sh, 3'b000}, func3_q);
                        state_d = RSP;
                    end
                end
            end
`ifdef LDU_MISALIGN_EN
            AR2: if (bus.arready) state_d = R2;
            R2: begin
                if (bus.rvalid) begin
                    err_d   = (bus.rresp != 2'b00);
                    data_d  = (bus.rresp != 2'b00) ? '0 : extend(merged[XLEN-1:0], func3_q);
                    state_d = RSP;
                end
            end
`endif
            RSP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            func3_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef LDU_MISALIGN_EN
            beat1_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            func3_q <= func3_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef LDU_MISALIGN_EN
            beat1_q <= beat1_d;
`endif
        end
    end

    // The address is re-derived from the latched request, so it reads zero while in reset.
    always_comb begin
        bus.araddr = ns_q ? addr_q : aligned;
`ifdef LDU_MISALIGN_EN
        if (state_q == AR2) bus.araddr = aligned + 32'(BYTES);
`endif
    end

    assign bus.arsize    = {1'b0, func3_q[1:0]};
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RSP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
`ifdef LDU_MISALIGN_EN
    assign bus.arvalid   = (state_q == AR1) || (state_q == AR2);
    assign bus.rready    = (state_q == R1) || (state_q == R2);
`else
    assign bus.arvalid   = (state_q == AR1);
    assign bus.rready    = (state_q == R1);
`endif
endmodule

// File: tb/tb_load_data_unit.sv
// Directed bench for load_data_unit: drives 32-bit and 64-bit instances and checks hand-computed results.
// The expectations for line-crossing loads follow the LDU_MISALIGN_EN macro.
module tb_load_data_unit;
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    load_data_unit_if #(.XLEN(32)) b32 ();
    load_data_unit_if #(.XLEN(64)) b64 ();

    load_data_unit #(.XLEN(32)) u_dut32 (.clk_i(clk), .rst_i(rst), .bus(b32.master));
    load_data_unit #(.XLEN(64)) u_dut64 (.clk_i(clk), .rst_i(rst), .bus(b64.master));

    logic        sel64, req_valid, rsp_ready, arready, rvalid;
    logic [31:0] req_addr;
    logic [2:0]  req_func3;
    logic [63:0] rdata;
    logic [1:0]  rresp;

    assign b32.req_valid = req_valid & ~sel64;
    assign b32.req_addr  = req_addr;
    assign b32.req_func3 = req_func3;
    assign b32.rsp_ready = rsp_ready;
    assign b32.arready   = arready;
    assign b32.rvalid    = rvalid;
    assign b32.rdata     = rdata[31:0];
    assign b32.rresp     = rresp;

    assign b64.req_valid = req_valid & sel64;
    assign b64.req_addr  = req_addr;
    assign b64.req_func3 = req_func3;
    assign b64.rsp_ready = rsp_ready;
    assign b64.arready   = arready;
    assign b64.rvalid    = rvalid;
    assign b64.rdata     = rdata;
    assign b64.rresp     = rresp;

    logic        o_req_ready, o_rsp_valid, o_rsp_err, o_arvalid, o_rready;
    logic [63:0] o_rsp_data;
    logic [31:0] o_araddr;
    logic [2:0]  o_arsize;

    always_comb begin
        if (sel64) begin
            o_req_ready = b64.req_ready;
            o_rsp_valid = b64.rsp_valid;
            o_rsp_err   = b64.rsp_err;
            o_rsp_data  = b64.rsp_data;
            o_arvalid   = b64.arvalid;
            o_rready    = b64.rready;
            o_araddr    = b64.araddr;
            o_arsize    = b64.arsize;
        end else begin
            o_req_ready = b32.req_ready;
            o_rsp_valid = b32.rsp_valid;
            o_rsp_err   = b32.rsp_err;
            o_rsp_data  = {32'h0, b32.rsp_data};
            o_arvalid   = b32.arvalid;
            o_rready    = b32.rready;
            o_araddr    = b32.araddr;
            o_arsize    = b32.arsize;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [63:0] beats [2];
    logic [1:0]  resps [2];
    logic [31:0] ar_log [2];
    logic [2:0]  ars_log;
    logic [63:0] got_data;
    logic        got_err;
    int          nar, lat, ar_cyc, r_cyc;
    bit          stable, idle_ok, done;

    task automatic set_beats(input logic [63:0] b0, input logic [63:0] b1, input logic [1:0] r0);
        beats[0] = b0;
        beats[1] = b1;
        resps[0] = r0;
        resps[1] = 2'b00;
    endtask

    // Called at a negedge with the selected DUT idle; arready/rvalid are always offered immediately.
    task automatic run_load(input bit s64, input logic [31:0] a, input logic [2:0] f3, input int hold);
        int h;
        int bi;
        bit acked;
        sel64 = s64;
        req_addr = a; req_func3 = f3; req_valid = 1'b1;
        rsp_ready = 1'b0; arready = 1'b1; rvalid = 1'b1;
        rdata = beats[0]; rresp = resps[0];
        nar = 0; lat = -1; ar_cyc = -1; r_cyc = -1;
        stable = 1'b1; idle_ok = 1'b0; done = 1'b0;
        h = 0; bi = 0; acked = 1'b0;
        ar_log[0] = '0; ar_log[1] = '0; ars_log = '0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (acked) begin
                idle_ok   = o_req_ready && !o_rsp_valid;
                rsp_ready = 1'b0;
                done      = 1'b1;
            end else begin
                if (o_arvalid) begin
                    if (ar_cyc < 0) ar_cyc = c;
                    if (nar < 2) ar_log[nar] = o_araddr;
                    ars_log = o_arsize;
                    nar++;
                end
                rdata = beats[bi];
                rresp = resps[bi];
                if (o_rready) begin
                    if (r_cyc < 0) r_cyc = c;
                    if (bi < 1) bi++;
                end
                if (o_rsp_valid) begin
                    if (lat < 0) begin
                        lat = c; got_data = o_rsp_data; got_err = o_rsp_err;
                    end else if (o_rsp_data !== got_data || o_rsp_err !== got_err) begin
                        stable = 1'b0;
                    end
                    if (h >= hold) begin
                        rsp_ready = 1'b1; acked = 1'b1;
                    end else begin
                        h++;
                    end
                end
            end
        end
        check_eq("done", 64'(done), 64'd1);
    endtask

    bit spurious;

    initial begin
        rst = 1'b1; sel64 = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        arready = 1'b0; rvalid = 1'b0; req_addr = '0; req_func3 = '0; rdata = '0; rresp = '0;
        set_beats(64'h0, 64'h0, 2'b00);
        repeat (2) @(negedge clk);
        check_eq("rst_arvalid",  64'(o_arvalid),   64'd0);
        check_eq("rst_rready",   64'(o_rready),    64'd0);
        check_eq("rst_rsp_vld",  64'(o_rsp_valid), 64'd0);
        check_eq("rst_rsp_err",  64'(o_rsp_err),   64'd0);
        check_eq("rst_rsp_data", o_rsp_data,       64'd0);
        check_eq("rst_araddr",   64'(o_araddr),    64'd0);
        check_eq("rst_arsize",   64'(o_arsize),    64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_req_rdy",  64'(o_req_ready), 64'd1);

        // LB, lane 3, negative byte
        set_beats(64'h80FF_1234, 64'h0, 2'b00);
        run_load(1'b0, 32'h8000_0003, 3'b000, 0);
        check_eq("lb_araddr", 64'(ar_log[0]), 64'h8000_0000);
        check_eq("lb_nar",    64'(nar),       64'd1);
        check_eq("lb_arsize", 64'(ars_log),   64'd0);
        check_eq("lb_ar_cyc", 64'(ar_cyc),    64'd1);
        check_eq("lb_r_cyc",  64'(r_cyc),     64'd2);
        check_eq("lb_lat",    64'(lat),       64'd3);
        check_eq("lb_data",   got_data,       64'hFFFF_FF80);
        check_eq("lb_err",    64'(got_err),   64'd0);
        check_eq("lb_idle",   64'(idle_ok),   64'd1);

        // LHU in UART region: exact address, lane 0
        set_beats(64'h0000_ABCD, 64'h0, 2'b00);
        run_load(1'b0, 32'h1000_0001, 3'b101, 0);
        check_eq("uart_araddr", 64'(ar_log[0]), 64'h1000_0001);
        check_eq("uart_arsize", 64'(ars_log),   64'd1);
        check_eq("uart_data",   got_data,       64'h0000_ABCD);
        check_eq("uart_lat",    64'(lat),       64'd3);

        // LW crossing a word boundary
        set_beats(64'h4433_2211, 64'h8877_6655, 2'b00);
        run_load(1'b0, 32'h8000_0002, 3'b010, 0);
`ifdef LDU_MISALIGN_EN
        check_eq("mis_nar",     64'(nar),       64'd2);
        check_eq("mis_araddr0", 64'(ar_log[0]), 64'h8000_0000);
        check_eq("mis_araddr1", 64'(ar_log[1]), 64'h8000_0004);
        check_eq("mis_data",    got_data,       64'h6655_4433);
        check_eq("mis_err",     64'(got_err),   64'd0);
        check_eq("mis_lat",     64'(lat),       64'd5);
`else
        check_eq("mis_nar",     64'(nar),       64'd0);
        check_eq("mis_err",     64'(got_err),   64'd1);
        check_eq("mis_data",    got_data,       64'd0);
        check_eq("mis_lat",     64'(lat),       64'd1);
`endif

        set_beats(64'h8001_0000, 64'h0, 2'b00);
        run_load(1'b0, 32'h8000_0002, 3'b001, 0);
        check_eq("lh_data", got_data, 64'hFFFF_8001);
        check_eq("lh_lat",  64'(lat), 64'd3);

        set_beats(64'h0000_F500, 64'h0, 2'b00);
        run_load(1'b0, 32'h8000_0001, 3'b100, 0);
        check_eq("lbu_data", got_data, 64'h0000_00F5);

        // RV64-only encodings on the 32-bit unit
        set_beats(64'h1111_2222, 64'h0, 2'b00);
        run_load(1'b0, 32'h8000_0000, 3'b011, 0);
        check_eq("ld32_err", 64'(got_err), 64'd1);
        check_eq("ld32_nar", 64'(nar),     64'd0);
        check_eq("ld32_lat", 64'(lat),     64'd1);
        run_load(1'b0, 32'h8000_0000, 3'b110, 0);
        check_eq("lwu32_err",  64'(got_err), 64'd1);
        check_eq("lwu32_data", got_data,     64'd0);

        // MROM and flash regions: exact address even when misaligned, no crossing
        set_beats(64'h1234_5678, 64'h0, 2'b00);
        run_load(1'b0, 32'h2000_0002, 3'b010, 0);
        check_eq("mrom_araddr", 64'(ar_log[0]), 64'h2000_0002);
        check_eq("mrom_data",   got_data,       64'h1234_5678);
        check_eq("mrom_lat",    64'(lat),       64'd3);
        set_beats(64'h0000_00A5, 64'h0, 2'b00);
        run_load(1'b0, 32'h3123_4567, 3'b000, 0);
        check_eq("flash_araddr", 64'(ar_log[0]), 64'h3123_4567);
        check_eq("flash_data",   got_data,       64'hFFFF_FFA5);

        // Reset while waiting for the read beat
        sel64 = 1'b0; req_addr = 32'h8000_0000; req_func3 = 3'b010;
        req_valid = 1'b1; arready = 1'b1; rvalid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("mid_arvalid", 64'(o_arvalid), 64'd1);
        @(negedge clk);
        check_eq("mid_rready", 64'(o_rready), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_rready",  64'(o_rready),    64'd0);
        check_eq("mid_rst_arvalid", 64'(o_arvalid),   64'd0);
        check_eq("mid_rst_data",    o_rsp_data,       64'd0);
        check_eq("mid_rst_araddr",  64'(o_araddr),    64'd0);
        @(negedge clk);
        rst = 1'b0; rvalid = 1'b1; rdata = 64'h5555_5555;
        spurious = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_rsp_valid || o_arvalid || o_rready || !o_req_ready) spurious = 1'b1;
        end
        check_eq("mid_no_rsp", 64'(spurious), 64'd0);

        // Error response on the first beat, response held off for 5 cycles
        set_beats(64'hDEAD_BEEF, 64'h0, 2'b10);
        run_load(1'b0, 32'h8000_0000, 3'b010, 5);
        check_eq("rerr_err",    64'(got_err), 64'd1);
        check_eq("rerr_data",   got_data,     64'd0);
        check_eq("rerr_nar",    64'(nar),     64'd1);
        check_eq("rerr_stable", 64'(stable),  64'd1);
        check_eq("rerr_idle",   64'(idle_ok), 64'd1);
`ifdef LDU_MISALIGN_EN
        set_beats(64'hDEAD_BEEF, 64'h0, 2'b10);
        run_load(1'b0, 32'h8000_0003, 3'b001, 0);
        check_eq("rerr_x_nar", 64'(nar),     64'd1);
        check_eq("rerr_x_err", 64'(got_err), 64'd1);
`endif

        // 64-bit unit
        set_beats(64'h8765_4321_0000_0000, 64'h0, 2'b00);
        run_load(1'b1, 32'h8000_0004, 3'b110, 0);
        check_eq("lwu64_araddr", 64'(ar_log[0]), 64'h8000_0000);
        check_eq("lwu64_data",   got_data,       64'h0000_0000_8765_4321);
        check_eq("lwu64_lat",    64'(lat),       64'd3);
        run_load(1'b1, 32'h8000_0004, 3'b010, 0);
        check_eq("lw64_data", got_data, 64'hFFFF_FFFF_8765_4321);
        set_beats(64'h1122_3344_5566_7788, 64'h0, 2'b00);
        run_load(1'b1, 32'h8000_0008, 3'b011, 0);
        check_eq("ld64_araddr", 64'(ar_log[0]), 64'h8000_0008);
        check_eq("ld64_arsize", 64'(ars_log),   64'd3);
        check_eq("ld64_data",   got_data,       64'h1122_3344_5566_7788);
        set_beats(64'h7F00_0000_0000_0000, 64'h0, 2'b00);
        run_load(1'b1, 32'h8000_0007, 3'b000, 0);
        check_eq("lb64_data", got_data,     64'h0000_0000_0000_007F);
        check_eq("lb64_err",  64'(got_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/load_data_unit.md
LOAD_DATA_UNIT -- requirements
Module: load_data_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, load result and bus data width; legal values 32 and 64.
REQ-002 SHALL have parameters NS0_BASE/NS0_MASK, defaults 32'h2000_0000/32'hFFFF_F000, no-shift region 0 (MROM).
REQ-003 SHALL have parameters NS1_BASE/NS1_MASK, defaults 32'h1000_0000/32'hFFFF_FFF8, no-shift region 1 (UART).
REQ-004 SHALL have parameters NS2_BASE/NS2_MASK, defaults 32'h3000_0000/32'hF000_0000, no-shift region 2 (flash).
REQ-005 Ports: clock in 1 system clock; reset in 1 asynchronous, active-high reset.
REQ-006 Ports: req_valid in 1, req_ready out 1, req_addr in 32 byte address, req_func3 in 3 RISC-V load funct3.
REQ-007 Ports: rsp_valid out 1, rsp_ready in 1, rsp_data out XLEN extended result, rsp_err out 1 error flag.
REQ-008 Ports: arvalid out 1, arready in 1, araddr out 32, arsize out 3 log2 bytes.
REQ-009 Ports: rvalid in 1, rready out 1, rdata in XLEN, rresp in 2 (nonzero = error).

Function
REQ-010 SHALL implement FSM IDLE, AR1, R1, AR2, R2, RSP; req_ready=1 only in IDLE.
REQ-011 Request handshake in IDLE SHALL latch addr/func3 and go to AR1 next cycle.
REQ-012 Access size: func3[1:0] 00=1B, 01=2B, 10=4B, 11=8B; func3[2]=zero-extend; func3 011/110 legal only when XLEN=64, otherwise rsp_err=1 with no bus access.
REQ-013 No-shift address (addr&NSn_MASK)==NSn_BASE for any n: araddr=req_addr exactly, single beat, data taken from lane 0.
REQ-014 Other addresses: beat1 araddr = addr aligned down to XLEN/8; offset = addr low bits; arsize = access size.
REQ-015 Crossing access (offset+size > XLEN/8): beat2 araddr = beat1 araddr + XLEN/8 via AR2/R2; merged data = {beat2,beat1} >> 8*offset.
REQ-016 Non-crossing access: data = beat1 >> 8*offset; AR1->R1->RSP.
REQ-017 arvalid SHALL be 1 exactly in AR1/AR2, held with araddr/arsize stable until arready; then move to R1/R2.
REQ-018 rready SHALL be 1 exactly in R1/R2; beat captured on rvalid&&rready.
REQ-019 rresp!=0 on either beat: rsp_err=1, rsp_data=0, remaining beat skipped, go to RSP.
REQ-020 Result SHALL be low size bytes sign- or zero-extended to XLEN; 4B sign-extends bit 31 when XLEN=64.
REQ-021 rsp_valid=1 only in RSP; rsp_data/rsp_err stable until rsp_ready, then IDLE; a new request is accepted the cycle after.
REQ-022 Minimum latency with immediate arready/rvalid: handshake cycle 0, arvalid cycle 1, rready cycle 2, rsp_valid cycle 3; crossing adds 2 cycles.

Reset
REQ-023 reset asserted SHALL asynchronously force IDLE, arvalid=rready=rsp_valid=rsp_err=0, rsp_data=0, araddr=0, arsize=0.
REQ-024 Reset mid-transaction SHALL abandon it; no response is produced for it after reset release.

Configuration
REQ-025 Macro LDU_MISALIGN_EN defined: crossing accesses use two beats per REQ-015.
REQ-026 LDU_MISALIGN_EN undefined: AR2/R2 absent; crossing access SHALL issue no bus request, go IDLE->RSP with rsp_err=1, rsp_data=0 (rsp_valid cycle 1).

Verification
REQ-027 XLEN=32, LB addr 0x8000_0003, rdata 0x80FF_1234 -> araddr 0x8000_0000, rsp_data 0xFFFF_FF80, rsp_valid cycle 3.
REQ-028 XLEN=32, LHU addr 0x1000_0001 (UART), rdata 0x0000_ABCD -> araddr 0x1000_0001, rsp_data 0x0000_ABCD.
REQ-029 XLEN=32, LW addr 0x8000_0002 with LDU_MISALIGN_EN, beats 0x4433_2211 then 0x8877_6655 -> araddr 0x8000_0000 then 0x8000_0004, rsp_data 0x6655_4433; without macro -> no arvalid, rsp_err=1.
REQ-030 XLEN=64, LWU addr 0x8000_0004, rdata 0x8765_4321_0000_0000 -> rsp_data 0x0000_0000_8765_4321; LW same data -> 0xFFFF_FFFF_8765_4321.
REQ-031 Beat1 rresp=2 -> rsp_err=1, rsp_data=0, no second AR; rsp_ready held low 5 cycles -> rsp_valid/data stable throughout.
REQ-032 reset pulsed while in R1 with arready seen -> outputs zero immediately, req_ready=1 after release, no rsp_valid.
